// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and depth derivation for the register file slice
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Number of architectural registers addressed by an addr_w-bit index
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// rtl/reg_file_scoreboard_if.sv - read/write/issue bus of the register file scoreboard
interface reg_file_scoreboard_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              Reg_Write_i;
    logic [ADDR_W-1:0] Write_Register_i;
    logic [DATA_W-1:0] Write_Data_i;
    logic [ADDR_W-1:0] Read_Register_1_i;
    logic [ADDR_W-1:0] Read_Register_2_i;
    logic [DATA_W-1:0] Read_Data_1_o;
    logic [DATA_W-1:0] Read_Data_2_o;
    logic              Read_Ready_1_o;
    logic              Read_Ready_2_o;
    logic              Issue_i;
    logic [ADDR_W-1:0] Issue_Register_i;
    logic              Issue_Err_o;
    logic [ADDR_W:0]   Pending_Count_o;

    modport master (
        output Reg_Write_i, Write_Register_i, Write_Data_i,
        output Read_Register_1_i, Read_Register_2_i,
        output Issue_i, Issue_Register_i,
        input  Read_Data_1_o, Read_Data_2_o, Read_Ready_1_o, Read_Ready_2_o,
        input  Issue_Err_o, Pending_Count_o
    );

    modport slave (
        input  Reg_Write_i, Write_Register_i, Write_Data_i,
        input  Read_Register_1_i, Read_Register_2_i,
        input  Issue_i, Issue_Register_i,
        output Read_Data_1_o, Read_Data_2_o, Read_Ready_1_o, Read_Ready_2_o,
        output Issue_Err_o, Pending_Count_o
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits, pending count and double-issue error
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_set,
    input  logic [ADDR_W-1:0]            i_set_reg,
    input  logic                         i_clr,
    input  logic [ADDR_W-1:0]            i_clr_reg,
    output logic [depth_of(ADDR_W)-1:0]  o_pending,
    output logic                         o_issue_err,
    output logic [ADDR_W:0]              o_count
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_next_pending;
    logic             r_issue_err;
    logic [ADDR_W:0]  r_count;
    logic             w_same_addr;
    logic             w_inc;
    logic             w_dec;
    logic             w_err;

    assign w_same_addr = i_set && i_clr && (i_set_reg == i_clr_reg);
    // A set only grows the count when the bit was clear; a clear only shrinks it
    // when the bit was set and no issue to the same register overrides it.
    assign w_inc = i_set && !r_pending[i_set_reg];
    assign w_dec = i_clr && r_pending[i_clr_reg] && !w_same_addr;
    assign w_err = i_set && r_pending[i_set_reg] && !w_same_addr;

    // Next pending vector: clear from the writer, then set from the issuer so a new producer wins
    always_comb begin
        w_next_pending = r_pending;
        if (i_clr) w_next_pending[i_clr_reg] = 1'b0;
        if (i_set) w_next_pending[i_set_reg] = 1'b1;
    end

    // Register pending bits, running popcount and the one-cycle error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending   <= '0;
            r_count     <= '0;
            r_issue_err <= 1'b0;
        end else begin
            r_pending   <= w_next_pending;
            r_issue_err <= w_err;
            if (w_inc && !w_dec)      r_count <= r_count + (ADDR_W+1)'(1);
            else if (w_dec && !w_inc) r_count <= r_count - (ADDR_W+1)'(1);
        end
    end

    assign o_pending   = r_pending;
    assign o_issue_err = r_issue_err;
    assign o_count     = r_count;

endmodule

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - two-read one-write register file with write forwarding and scoreboard
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    reg_file_scoreboard_if.slave    bus
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  w_pending;
    logic              w_wr_en;
    logic              w_iss_en;
    logic              w_fwd_en;

    // Register 0 swallows writes and issues when it is hardwired to zero
    assign w_wr_en  = bus.Reg_Write_i && !(ZERO_REG != 0 && bus.Write_Register_i == '0);
    assign w_iss_en = bus.Issue_i && !(ZERO_REG != 0 && bus.Issue_Register_i == '0);
    // Forwarding is suppressed during reset so reads show the array itself
    assign w_fwd_en = (BYPASS != 0) && w_wr_en && !reset;

    // Data array: cleared on reset, otherwise one write per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[bus.Write_Register_i] <= bus.Write_Data_i;
        end
    end

    // Read port 1: zero register, then forwarded write data, then array contents
    always_comb begin
        bus.Read_Data_1_o  = r_regs[bus.Read_Register_1_i];
        bus.Read_Ready_1_o = !w_pending[bus.Read_Register_1_i];
        if (w_fwd_en && bus.Write_Register_i == bus.Read_Register_1_i) begin
            bus.Read_Data_1_o  = bus.Write_Data_i;
            bus.Read_Ready_1_o = 1'b1;
        end
        if (ZERO_REG != 0 && bus.Read_Register_1_i == '0) begin
            bus.Read_Data_1_o  = '0;
            bus.Read_Ready_1_o = 1'b1;
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        bus.Read_Data_2_o  = r_regs[bus.Read_Register_2_i];
        bus.Read_Ready_2_o = !w_pending[bus.Read_Register_2_i];
        if (w_fwd_en && bus.Write_Register_i == bus.Read_Register_2_i) begin
            bus.Read_Data_2_o  = bus.Write_Data_i;
            bus.Read_Ready_2_o = 1'b1;
        end
        if (ZERO_REG != 0 && bus.Read_Register_2_i == '0) begin
            bus.Read_Data_2_o  = '0;
            bus.Read_Ready_2_o = 1'b1;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .i_set       (w_iss_en),
        .i_set_reg   (bus.Issue_Register_i),
        .i_clr       (w_wr_en),
        .i_clr_reg   (bus.Write_Register_i),
        .o_pending   (w_pending),
        .o_issue_err (bus.Issue_Err_o),
        .o_count     (bus.Pending_Count_o)
    );

endmodule
